// File: rtl/apb_pkg.sv
// Shared state encoding and AHB-Lite constants for the AHB-to-APB bridge.
package apb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WLATCH = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      DONE   = 3'd4,
      ERR1   = 3'd5,
      ERR2   = 3'd6
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_slave_mux.sv
// Routes the addressed APB slave's read data, ready and error back to the bridge FSM.
module apb_slave_mux
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 3,
   parameter int IDX_W   = 2
) (
   input  logic [IDX_W-1:0]      idx,
   input  logic [32*NUM_SLV-1:0] prdata,
   input  logic [NUM_SLV-1:0]    pready,
   input  logic [NUM_SLV-1:0]    pslverr,
   output logic [31:0]           rdata,
   output logic                  ready,
   output logic                  slverr
);

   always_comb begin
      rdata  = '0;
      ready  = 1'b0;
      slverr = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx == IDX_W'(i)) begin
            rdata  = prdata[32*i +: 32];
            ready  = pready[i];
            slverr = pslverr[i];
         end
      end
   end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB transfer per AHB transfer, errors
// (slave error, decode miss, non-word size, stalled slave) returned as a two-cycle ERROR.
//
// state  | meaning
// IDLE   | no transfer pending, zero-wait OKAY, capture enabled
// WLATCH | write captured, latching HWDATA into PWDATA
// SETUP  | APB setup phase, PSEL high
// ACCESS | APB access phase, waiting on PREADY or timeout
// DONE   | OKAY completion, capture enabled
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, capture enabled
module ahb_apb_bridge
   import apb_pkg::*;
#(
   parameter int NUM_SLV     = 3,
   parameter int IDX_W       = 2,
   parameter int OFFSET_W    = 12,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [31:0]           PADDR,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [NUM_SLV-1:0]    PSEL,
   output logic                  PENABLE,
   input  logic [32*NUM_SLV-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]    PREADY,
   input  logic [NUM_SLV-1:0]    PSLVERR
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   state_t               state;
   state_t               state_nxt;
   state_t               cap_state;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     cap_idx;
   logic [IDX_W-1:0]     sel_idx;
   logic [NUM_SLV-1:0]   setup_sel;
   logic [7:0]           cnt;
   logic [7:0]           cnt_inc;
   logic                 capture;
   logic                 cap_window;
   logic                 cap_err;
   logic                 capture_ok;
   logic                 timeout;
   logic [31:0]          sl_rdata;
   logic                 sl_ready;
   logic                 sl_err;

   apb_slave_mux #(
      .NUM_SLV (NUM_SLV),
      .IDX_W   (IDX_W)
   ) u_slave_mux (
      .idx     (idx_q),
      .prdata  (PRDATA),
      .pready  (PREADY),
      .pslverr (PSLVERR),
      .rdata   (sl_rdata),
      .ready   (sl_ready),
      .slverr  (sl_err)
   );

   always_comb begin
      capture    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
      cap_window = (state == IDLE) | (state == DONE) | (state == ERR2);
      cap_idx    = HADDR[OFFSET_W +: IDX_W];
      cap_err    = (32'(cap_idx) >= 32'(NUM_SLV)) | (HSIZE != HSIZE_WORD);
      capture_ok = cap_window & capture & ~cap_err;
      cap_state  = cap_err ? ERR1 : (HWRITE ? WLATCH : SETUP);
      cnt_inc    = cnt + 8'd1;
      timeout    = (cnt_inc == TIMEOUT_LIM) & ~sl_ready;

      // A read goes straight from capture to SETUP, so the select must come from HADDR then.
      sel_idx   = (state == WLATCH) ? idx_q : cap_idx;
      setup_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         setup_sel[i] = (sel_idx == IDX_W'(i));
      end

      state_nxt = state;
      case (state)
         IDLE, DONE, ERR2: state_nxt = capture ? cap_state : IDLE;
         WLATCH:           state_nxt = SETUP;
         SETUP:            state_nxt = ACCESS;
         ACCESS: begin
            if (sl_ready) begin
               state_nxt = sl_err ? ERR1 : DONE;
            end else if (timeout) begin
               state_nxt = ERR1;
            end
         end
         ERR1:             state_nxt = ERR2;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx_q   <= '0;
         cnt     <= '0;
         PADDR   <= '0;
         PWRITE  <= 1'b0;
         PWDATA  <= '0;
         PSEL    <= '0;
         PENABLE <= 1'b0;
         HRDATA  <= '0;
      end else begin
         state <= state_nxt;

         if (capture_ok) begin
            idx_q  <= cap_idx;
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
         end

         if (state == WLATCH) begin
            PWDATA <= HWDATA;
         end

         if (state == ACCESS) begin
            cnt <= cnt_inc;
         end else if (state_nxt == SETUP) begin
            cnt <= '0;
         end

         if (state_nxt == SETUP) begin
            PSEL    <= setup_sel;
            PENABLE <= 1'b0;
         end else if (state_nxt == ACCESS) begin
            PENABLE <= 1'b1;
         end else begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
         end

         if ((state == ACCESS) && sl_ready && !sl_err && !PWRITE) begin
            HRDATA <= sl_rdata;
         end
      end
   end

   assign HREADYOUT = ~((state == WLATCH) | (state == SETUP) | (state == ACCESS) | (state == ERR1));
   assign HRESP     = ((state == ERR1) | (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: pipelined AHB master, behavioural APB slaves.
module tb_ahb_apb_bridge;

   localparam int NUM_SLV = 3;
   localparam int TO      = 8;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          stall;
      logic        slverr;
   } txn_t;

   typedef struct {
      logic        dec_err;
      logic        resp;
      logic [31:0] rdata;
      int          waits;
      logic [2:0]  psel;
      int          psel_cyc;
      int          pen_cyc;
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  hsel;
   logic [31:0]           haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [31:0]           hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic                  hresp;
   logic [31:0]           hrdata;
   logic [31:0]           paddr;
   logic                  pwrite;
   logic [31:0]           pwdata;
   logic [NUM_SLV-1:0]    psel;
   logic                  penable;
   logic [32*NUM_SLV-1:0] prdata;
   logic [NUM_SLV-1:0]    pready;
   logic [NUM_SLV-1:0]    pslverr;

   logic [31:0] slave_data [NUM_SLV];
   int          stall_cfg;
   logic        err_cfg;
   int          acc_cnt;
   logic        rdy;

   int          psel_cyc;
   int          pen_cyc;
   logic [2:0]  mon_psel;
   logic [31:0] mon_paddr;
   logic        mon_pwrite;
   logic [31:0] mon_pwdata;
   logic        mon_bad;

   txn_t        stim_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_hrdata;
   int          n_checks;
   int          n_errors;

   always #5 clk = ~clk;

   assign hready = hreadyout;
   assign prdata = {slave_data[2], slave_data[1], slave_data[0]};

   ahb_apb_bridge #(
      .NUM_SLV     (NUM_SLV),
      .IDX_W       (2),
      .OFFSET_W    (12),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .HSEL      (hsel),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HWDATA    (hwdata),
      .HREADY    (hready),
      .HREADYOUT (hreadyout),
      .HRESP     (hresp),
      .HRDATA    (hrdata),
      .PADDR     (paddr),
      .PWRITE    (pwrite),
      .PWDATA    (pwdata),
      .PSEL      (psel),
      .PENABLE   (penable),
      .PRDATA    (prdata),
      .PREADY    (pready),
      .PSLVERR   (pslverr)
   );

   // APB slaves: ready after stall_cfg access cycles, all slaves share the stall/error config.
   always @(negedge clk) begin
      if (psel != '0 && penable) begin
         rdy = (acc_cnt >= stall_cfg);
         acc_cnt++;
      end else begin
         rdy     = 1'b0;
         acc_cnt = 0;
      end
      pready  = {NUM_SLV{rdy}};
      pslverr = {NUM_SLV{rdy & err_cfg}};
   end

   always @(negedge clk) begin
      if (psel != '0) begin
         if (psel_cyc == 0) begin
            mon_psel   = psel;
            mon_paddr  = paddr;
            mon_pwrite = pwrite;
            mon_pwdata = pwdata;
            if (penable) mon_bad = 1'b1;
         end else if (psel != mon_psel || paddr != mon_paddr || pwrite != mon_pwrite ||
                      pwdata != mon_pwdata) begin
            mon_bad = 1'b1;
         end
         psel_cyc++;
         if (penable) pen_cyc++;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_txn(input logic [31:0] addr, input logic write, input logic [2:0] size,
                          input logic [31:0] wdata, input int stall, input logic slverr);
      txn_t t;
      t.addr = addr; t.write = write; t.size = size;
      t.wdata = wdata; t.stall = stall; t.slverr = slverr;
      stim_q.push_back(t);
   endtask

   task automatic push_exp(input txn_t t);
      exp_t e;
      int   idx;
      int   acc;
      logic err;
      idx       = int'(t.addr[13:12]);
      e.dec_err = (idx >= NUM_SLV) || (t.size != 3'b010);
      e.paddr   = t.addr;
      e.pwrite  = t.write;
      e.pwdata  = t.wdata;
      if (e.dec_err) begin
         e.resp = 1'b1; e.waits = 1; e.psel = '0; e.psel_cyc = 0; e.pen_cyc = 0;
      end else begin
         acc        = (t.stall >= TO) ? TO : t.stall + 1;
         err        = (t.stall >= TO) || t.slverr;
         e.resp     = err;
         e.psel     = 3'(1 << idx);
         e.pen_cyc  = acc;
         e.psel_cyc = acc + 1;
         e.waits    = (t.write ? 1 : 0) + 1 + acc + (err ? 1 : 0);
         if (!t.write && !err) model_hrdata = slave_data[idx];
      end
      e.rdata = model_hrdata;
      exp_q.push_back(e);
   endtask

   task automatic drive_addr(input txn_t t);
      hsel   = 1'b1;
      haddr  = t.addr;
      htrans = 2'b10;
      hwrite = t.write;
      hsize  = t.size;
   endtask

   // Issues every queued transfer; each next address phase overlaps the previous completion cycle.
   task automatic run_burst();
      txn_t cur;
      exp_t e;
      int   waits;
      logic done;
      logic resp;
      logic last_wait_resp;
      logic [31:0] rdata;
      @(negedge clk);
      cur = stim_q.pop_front();
      drive_addr(cur);
      push_exp(cur);
      forever begin
         @(posedge clk);
         #1;
         hsel      = 1'b0;
         htrans    = 2'b00;
         hwdata    = cur.wdata;
         stall_cfg = cur.stall;
         err_cfg   = cur.slverr;
         psel_cyc  = 0; pen_cyc = 0; mon_psel = '0; mon_bad = 1'b0;
         waits = 0; done = 1'b0; last_wait_resp = 1'b0;
         for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (hreadyout) begin
               done = 1'b1;
            end else begin
               waits++;
               last_wait_resp = hresp;
            end
         end
         chk_eq("completion", 32'(done), 32'd1);
         resp  = hresp;
         rdata = hrdata;
         e = exp_q.pop_front();
         chk_eq("hresp", 32'(resp), 32'(e.resp));
         chk_eq("hrdata", rdata, e.rdata);
         chk_eq("wait_states", 32'(waits), 32'(e.waits));
         chk_eq("last_wait_hresp", 32'(last_wait_resp), 32'(e.resp));
         chk_eq("psel", 32'(mon_psel), 32'(e.psel));
         chk_eq("psel_cycles", 32'(psel_cyc), 32'(e.psel_cyc));
         chk_eq("penable_cycles", 32'(pen_cyc), 32'(e.pen_cyc));
         if (!e.dec_err) begin
            chk_eq("paddr", mon_paddr, e.paddr);
            chk_eq("pwrite", 32'(mon_pwrite), 32'(e.pwrite));
            chk_eq("apb_stable", 32'(mon_bad), 32'd0);
            if (e.pwrite) chk_eq("pwdata", mon_pwdata, e.pwdata);
         end
         if (!done || stim_q.size() == 0) break;
         cur = stim_q.pop_front();
         drive_addr(cur);
         push_exp(cur);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_psel"}, 32'(psel), 32'd0);
      chk_eq({tag, "_penable"}, 32'(penable), 32'd0);
      chk_eq({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
      chk_eq({tag, "_hresp"}, 32'(hresp), 32'd0);
      chk_eq({tag, "_hrdata"}, hrdata, 32'd0);
      chk_eq({tag, "_paddr"}, paddr, 32'd0);
      chk_eq({tag, "_pwdata"}, pwdata, 32'd0);
      chk_eq({tag, "_pwrite"}, 32'(pwrite), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0; n_errors = 0; model_hrdata = '0;
      slave_data[0] = 32'h1111_0000;
      slave_data[1] = 32'hDEAD_BEEF;
      slave_data[2] = 32'h2222_2222;
      stall_cfg = 0; err_cfg = 1'b0; acc_cnt = 0; rdy = 1'b0;
      psel_cyc = 0; pen_cyc = 0; mon_psel = '0; mon_bad = 1'b0;
      mon_paddr = '0; mon_pwrite = 1'b0; mon_pwdata = '0;
      pready = '0; pslverr = '0;
      hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      add_txn(32'h0000_1004, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      run_burst();
      add_txn(32'h0000_0000, 1'b1, 3'b010, 32'hC000_0010, 0, 1'b0);
      run_burst();
      add_txn(32'h0000_2010, 1'b0, 3'b010, 32'h0, 4, 1'b1);
      run_burst();
      add_txn(32'h0000_3000, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      add_txn(32'h0000_1008, 1'b0, 3'b000, 32'h0, 0, 1'b0);
      add_txn(32'h0000_0004, 1'b1, 3'b001, 32'h0BAD_0BAD, 0, 1'b0);
      run_burst();
      add_txn(32'h0000_2000, 1'b0, 3'b010, 32'h0, 1000, 1'b0);
      add_txn(32'h0000_1000, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      run_burst();
      add_txn(32'h0000_2020, 1'b1, 3'b010, 32'h5A5A_0001, 2, 1'b0);
      add_txn(32'h0000_200C, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      add_txn(32'h0000_1010, 1'b1, 3'b010, 32'h1234_5678, 0, 1'b1);
      add_txn(32'h0000_0008, 1'b0, 3'b010, 32'h0, 7, 1'b0);
      run_burst();

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         hsel = 1'b1; haddr = 32'h0000_1000; hwrite = 1'b0; hsize = 3'b010;
         htrans = (k == 0) ? 2'b01 : 2'b00;
         @(negedge clk);
         chk_eq("idle_busy_hreadyout", 32'(hreadyout), 32'd1);
         chk_eq("idle_busy_hresp", 32'(hresp), 32'd0);
         chk_eq("idle_busy_psel", 32'(psel), 32'd0);
      end
      hsel = 1'b0; htrans = 2'b00;

      stall_cfg = 1000; err_cfg = 1'b0;
      @(negedge clk);
      hsel = 1'b1; haddr = 32'h0000_2008; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
      @(posedge clk);
      #1;
      hsel = 1'b0; htrans = 2'b00;
      repeat (3) @(negedge clk);
      chk_eq("pre_reset_penable", 32'(penable), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_hrdata = '0;
      chk_reset_state("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      add_txn(32'h0000_0004, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      run_burst();

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
